// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard.
//   r_t        : architectural register index (5 bits)
//   cnt_t      : per-register pending-write counter
//   ptot_t     : sum of all pending-write counts
package reg_scoreboard_pkg;

   localparam int unsigned R_W        = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned SB_CNT_W   = 2;
   localparam int unsigned SB_CNT_MAX = 3;
   localparam int unsigned PEND_TOT_W = 7;

   typedef logic [R_W-1:0]        r_t;
   typedef logic [SB_CNT_W-1:0]   cnt_t;
   typedef logic [PEND_TOT_W-1:0] ptot_t;

endpackage : reg_scoreboard_pkg

// File: rtl/sb_counter.sv
// Pending-write counter for one register: saturating up/down with clear.
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : zero the count (wins over inc/dec)
//   inc_i, dec_i : one issue / one writeback this cycle
//   cnt_o        : current count (registered)
//   cnt_nxt_c    : count after the next posedge
//   busy_c       : count != 0
//   underflow_c  : dec requested while count == 0 (ignored)
module sb_counter
   import reg_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic inc_i,
   input  logic dec_i,
   output cnt_t cnt_o,
   output cnt_t cnt_nxt_c,
   output logic busy_c,
   output logic underflow_c
);

   cnt_t cnt_q, cnt_d;
   logic dec_ok;

   // Next count; simultaneous inc and accepted dec cancel out.
   always_comb begin
      cnt_d       = cnt_q;
      underflow_c = dec_i & (cnt_q == '0);
      dec_ok      = dec_i & ~underflow_c;
      if (clear_i) begin
         cnt_d = '0;
      end else begin
         unique case ({inc_i, dec_ok})
            2'b10: if (cnt_q != cnt_t'(SB_CNT_MAX)) cnt_d = cnt_q + cnt_t'(1);
            2'b01: cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o     = cnt_q;
   assign cnt_nxt_c = cnt_d;
   assign busy_c    = (cnt_q != '0);

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per register and stalls issue
// on RAW hazards or when a destination already has the maximum in flight.
// Optional macro SB_BYPASS_EN: a source whose last pending write is being
// written back this cycle does not stall (value is forwarded).
//   clk, rst_n             : clock, async active-low reset
//   issue_valid            : instruction presented for issue
//   rs1_/rs2_addr, _rden   : source registers and read enables
//   rd_addr, rd_wren       : destination register and write enable
//   wb_valid, wb_rd_addr   : one register write retiring
//   flush                  : discard all pending-write tracking
//   issue_stall            : combinational hold for decode
//   busy_mask              : registered, bit n = register n pending
//   pending_total          : registered, sum of pending counts
//   sb_err                 : registered sticky writeback-without-pending flag
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   input  r_t                  rs1_addr,
   input  r_t                  rs2_addr,
   input  logic                rs1_rden,
   input  logic                rs2_rden,
   input  r_t                  rd_addr,
   input  logic                rd_wren,
   input  logic                wb_valid,
   input  r_t                  wb_rd_addr,
   input  logic                flush,
   output logic                issue_stall,
   output logic [NUM_REGS-1:0] busy_mask,
   output ptot_t               pending_total,
   output logic                sb_err
);

   cnt_t                cnt     [NUM_REGS];
   cnt_t                cnt_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] uflow;
   logic                issue_fire;
   logic                raw1, raw2, waw;

   logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;
   ptot_t               pending_total_q, pending_total_d;
   logic                sb_err_q, sb_err_d;

   // x0 is never tracked.
   assign cnt[0]     = '0;
   assign cnt_nxt[0] = '0;
   assign busy[0]    = 1'b0;
   assign uflow[0]   = 1'b0;

   for (genvar n = 1; n < NUM_REGS; n++) begin : g_cnt
      sb_counter u_cnt (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear_i     (flush),
         .inc_i       (issue_fire & rd_wren & (rd_addr == r_t'(n))),
         .dec_i       (wb_valid & (wb_rd_addr == r_t'(n))),
         .cnt_o       (cnt[n]),
         .cnt_nxt_c   (cnt_nxt[n]),
         .busy_c      (busy[n]),
         .underflow_c (uflow[n])
      );
   end

   // Hazard detection from current counts (also valid during a flush cycle).
   always_comb begin
      raw1 = rs1_rden & (rs1_addr != '0) & busy[rs1_addr];
      raw2 = rs2_rden & (rs2_addr != '0) & busy[rs2_addr];
      waw  = rd_wren & (rd_addr != '0) & (cnt[rd_addr] == cnt_t'(SB_CNT_MAX));
`ifdef SB_BYPASS_EN
      if (wb_valid & (wb_rd_addr == rs1_addr) & (cnt[rs1_addr] == cnt_t'(1))) raw1 = 1'b0;
      if (wb_valid & (wb_rd_addr == rs2_addr) & (cnt[rs2_addr] == cnt_t'(1))) raw2 = 1'b0;
`endif
      issue_stall = issue_valid & (raw1 | raw2 | waw);
      issue_fire  = issue_valid & ~issue_stall;
   end

   // Summary outputs track the post-edge counter state.
   always_comb begin
      busy_mask_d     = '0;
      pending_total_d = '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
         busy_mask_d[n]  = (cnt_nxt[n] != '0);
         pending_total_d = pending_total_d + ptot_t'(cnt_nxt[n]);
      end
      sb_err_d = flush ? 1'b0 : (sb_err_q | (|uflow));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_mask_q     <= '0;
         pending_total_q <= '0;
         sb_err_q        <= 1'b0;
      end else begin
         busy_mask_q     <= busy_mask_d;
         pending_total_q <= pending_total_d;
         sb_err_q        <= sb_err_d;
      end
   end

   assign busy_mask     = busy_mask_q;
   assign pending_total = pending_total_q;
   assign sb_err        = sb_err_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random
// traffic, compared against an array-of-integers model of pending writes.
module tb_reg_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_rd_addr;
   logic        rs1_rden, rs2_rden, rd_wren, wb_valid, flush;
   logic        issue_stall;
   logic [31:0] busy_mask;
   logic [6:0]  pending_total;
   logic        sb_err;

   reg_scoreboard dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid   (issue_valid),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_rden      (rs1_rden),
      .rs2_rden      (rs2_rden),
      .rd_addr       (rd_addr),
      .rd_wren       (rd_wren),
      .wb_valid      (wb_valid),
      .wb_rd_addr    (wb_rd_addr),
      .flush         (flush),
      .issue_stall   (issue_stall),
      .busy_mask     (busy_mask),
      .pending_total (pending_total),
      .sb_err        (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: number of outstanding writes per register.
   int m_cnt [32];
   bit m_err;
`ifdef SB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
   endtask

   function automatic bit m_raw(input int a, input bit en, input bit wbv, input int wba);
      if (!en || a == 0 || m_cnt[a] == 0) return 1'b0;
      if (BYPASS && wbv && wba == a && m_cnt[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b = '0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   function automatic int m_total();
      int s = 0;
      for (int i = 0; i < 32; i++) s += m_cnt[i];
      return s;
   endfunction

   task automatic drive_idle();
      issue_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_rden = 0; rs2_rden = 0;
      rd_addr = 0; rd_wren = 0; wb_valid = 0; wb_rd_addr = 0; flush = 0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 0;
   endtask

   // One cycle: drive, check the combinational stall, clock, update model, check state.
   task automatic step(input bit iv, input int r1, input bit r1e, input int r2, input bit r2e,
                       input int rd, input bit wen, input bit wbv, input int wba, input bit fl);
      bit exp_stall, fire, dec;
      @(negedge clk);
      issue_valid = iv; rs1_addr = 5'(r1); rs1_rden = r1e; rs2_addr = 5'(r2); rs2_rden = r2e;
      rd_addr = 5'(rd); rd_wren = wen; wb_valid = wbv; wb_rd_addr = 5'(wba); flush = fl;
      #1;
      exp_stall = iv && (m_raw(r1, r1e, wbv, wba) || m_raw(r2, r2e, wbv, wba) ||
                         (wen && rd != 0 && m_cnt[rd] == 3));
      check("issue_stall", 32'(issue_stall), 32'(exp_stall));
      fire = iv && !exp_stall;
      @(posedge clk);
      if (fl) begin
         model_clear();
      end else begin
         dec = wbv && wba != 0;
         if (dec && m_cnt[wba] == 0) begin
            m_err = 1;
            dec   = 0;
         end
         if (fire && wen && rd != 0) m_cnt[rd]++;
         if (dec) m_cnt[wba]--;
      end
      #1;
      check("busy_mask", busy_mask, m_busy());
      check("pending_total", 32'(pending_total), 32'(m_total()));
      check("sb_err", 32'(sb_err), 32'(m_err));
      drive_idle();
   endtask

   initial begin
      drive_idle();
      model_clear();
      rst_n = 0;
      #12;
      issue_valid = 1; rs1_addr = 5; rs1_rden = 1;
      #1;
      check("rst_stall", 32'(issue_stall), 32'd0);
      check("rst_busy", busy_mask, 32'd0);
      check("rst_total", 32'(pending_total), 32'd0);
      check("rst_err", 32'(sb_err), 32'd0);
      drive_idle();
      @(negedge clk);
      rst_n = 1;

      // RAW on r5, released by its writeback.
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      check("raw_busy5", 32'(busy_mask[5]), 32'd1);
      check("raw_total1", 32'(pending_total), 32'd1);
      step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
      step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      check("raw_clear", 32'(pending_total), 32'd0);

      // WAW saturation on r7.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
      step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      check("waw_cnt3", 32'(pending_total), 32'd3);

      // Same-cycle inc/dec on r9.
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
      check("incdec_total", 32'(pending_total), 32'd1);

      // x0 never tracked; writes to x0 silently ignored.
      step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
      check("x0_busy0", 32'(busy_mask[0]), 32'd0);

      // Underflow on r12, then flush (stall still from live counts).
      step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      check("uflow_err", 32'(sb_err), 32'd1);
      step(1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
      check("flush_err", 32'(sb_err), 32'd0);
      check("flush_total", 32'(pending_total), 32'd0);

      // Async reset mid-cycle with counters loaded.
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      #2;
      issue_valid = 1; rs1_addr = 3; rs1_rden = 1;
      rst_n = 0;
      #1;
      check("async_busy", busy_mask, 32'd0);
      check("async_total", 32'(pending_total), 32'd0);
      check("async_stall", 32'(issue_stall), 32'd0);
      model_clear();
      drive_idle();
      @(negedge clk);
      rst_n = 1;

      // Random traffic over a small register window to create hazards.
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 40) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_reg_scoreboard
